// File: rtl/fas_pkg.sv
// fas_pkg: shared constants, FSM states and bin field slices for the FFT analysis stage
package fas_pkg;
  localparam int NBIN = 16;
  localparam int DW = 16;
  localparam int MAGW = 32;
  localparam int BW = 2 * DW;
  localparam int IW = $clog2(NBIN);
  localparam int RE_HI = 31;
  localparam int RE_LO = 16;
  localparam int IM_HI = 15;
  localparam int IM_LO = 0;
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
endpackage

// File: rtl/fft_mag_sq.sv
// fft_mag_sq: combinational squared magnitude re^2 + im^2 of one complex bin
module fft_mag_sq import fas_pkg::*; (
  input  logic [BW-1:0]   bin,
  output logic [MAGW-1:0] mag
);
  logic signed [DW-1:0] re, im;
  logic signed [MAGW-1:0] rr, ii;
  assign re = bin[RE_HI:RE_LO];
  assign im = bin[IM_HI:IM_LO];
  assign rr = re * re;
  assign ii = im * im;
  // each square is at most 2^30, so the unsigned sum never wraps
  assign mag = $unsigned(rr) + $unsigned(ii);
endmodule

// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer: serially scans a captured 16-bin frame and reports the peak-magnitude bin index
module fft_peak_analyzer import fas_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          fft_valid,
  input  logic [BW-1:0] fft_d0,
  input  logic [BW-1:0] fft_d1,
  input  logic [BW-1:0] fft_d2,
  input  logic [BW-1:0] fft_d3,
  input  logic [BW-1:0] fft_d4,
  input  logic [BW-1:0] fft_d5,
  input  logic [BW-1:0] fft_d6,
  input  logic [BW-1:0] fft_d7,
  input  logic [BW-1:0] fft_d8,
  input  logic [BW-1:0] fft_d9,
  input  logic [BW-1:0] fft_d10,
  input  logic [BW-1:0] fft_d11,
  input  logic [BW-1:0] fft_d12,
  input  logic [BW-1:0] fft_d13,
  input  logic [BW-1:0] fft_d14,
  input  logic [BW-1:0] fft_d15,
  output logic          done,
  output logic [IW-1:0] freq,
  output logic          busy,
  output logic          ovf
);
  state_t state, state_n;
  logic [BW-1:0] din [NBIN];
  logic [BW-1:0] frame [NBIN];
  logic [BW-1:0] pbuf [NBIN];
  logic pending;
  logic [IW-1:0] idx, maxidx;
  logic [MAGW-1:0] peak, mag;
  assign din = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                 fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};
  fft_mag_sq u_mag (.bin(frame[idx]), .mag(mag));
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? ((fft_valid || pending) ? SCAN : IDLE)
            : state == SCAN ? (idx == IW'(NBIN - 1) ? REPORT : SCAN)
            : IDLE;
  always_comb busy = state != IDLE || pending;
  always_ff @(posedge clk)
    if (rst) begin
      done <= 1'b0;
      freq <= '0;
      ovf <= 1'b0;
      pending <= 1'b0;
      idx <= '0;
      peak <= '0;
      maxidx <= '0;
    end else begin
      done <= state == REPORT;
      if (state == REPORT) freq <= maxidx;
      // a waiting frame is always served before a newly arriving one
      if (state == IDLE && (fft_valid || pending)) begin
        frame <= pending ? pbuf : din;
        idx <= '0;
        peak <= '0;
        maxidx <= '0;
      end
      if (state == SCAN) begin
        if (mag > peak) begin
          peak <= mag;
          maxidx <= idx;
        end
        idx <= idx + 1'b1;
      end
      if (fft_valid && (state != IDLE || pending)) begin
        if (state != IDLE && pending) ovf <= 1'b1;
        else begin
          pbuf <= din;
          pending <= 1'b1;
        end
      end else if (state == IDLE && pending) pending <= 1'b0;
    end
endmodule
